int_exec_unit: RTL and testbench
================================

# int_exec_unit

Integer execution unit at the read end of the dispatcher's integer execution FIFO. It pops ready integer instructions, computes the ALU result in one cycle, and broadcasts the result and destination tag on the common data bus (CDB) under a request/grant handshake with the CDB arbiter. It implements in hardware the execute-and-broadcast role that the bench currently performs for integer operations.

## Interface
Parameters:
- TAG_W, 6, width of physical/ROB tags
- DATA_W, 32, operand and result width
- ENTRY_W, 101, integer FIFO entry width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- i_fifo_empty  in  1  integer FIFO empty flag
- i_fifo_data  in  ENTRY_W  FIFO head entry, show-ahead (valid whenever i_fifo_empty=0)
- o_fifo_rd  out  1  pop strobe; the head is consumed at the rising edge where this is 1
- o_cdb_req  out  1  result valid, requesting the CDB
- o_cdb_tag  out  TAG_W  destination tag of the pending result
- o_cdb_data  out  DATA_W  pending result
- i_cdb_grant  in  1  arbiter grant; the result is taken at the edge where req=grant=1
- i_flush  in  1  mispredict flush; drops the pending result
- o_operand_err  out  1  one-cycle pulse: a popped entry had an operand valid bit = 0

## Operation
- Entry layout: [100:94] opcode, [93:91] func3, [90:84] func7, [83:52] rs1_data, [51] rs1_valid, [50:45] rs1_tag, [44:13] rs2_data, [12] rs2_valid, [11:6] rs2_tag, [5:0] rd_tag.
- For I-type, rs2_data already holds the sign-extended immediate.
- State: a single result register (valid, tag, data). FSM has two states:
  - IDLE: valid=0.
  - REQ: valid=1.
- Pop condition, combinational: o_fifo_rd = !i_fifo_empty && !i_flush && !rst && (!valid || i_cdb_grant).
- On a pop, opcode 7'h00 is a bubble. It is consumed and discarded, and the next state is IDLE if the current result was granted (or none was pending).
- R_TYPE (7'h33), selected by func3/func7:
  - 0/00 ADD, 0/20 SUB
  - 1 SLL, 2 SLT (signed), 3 SLTU
  - 4 XOR, 5/00 SRL, 5/20 SRA
  - 6 OR, 7 AND
- I_TYPE (7'h13), selected by func3:
  - 0 ADDI, 1 SLLI, 2 SLTI, 3 SLTIU
  - 4 XORI, 5 SRLI/SRAI (func7 00/20), 6 ORI, 7 ANDI
- Arithmetic rules: add/sub wrap modulo 2^32. Shift amount is b[4:0]. SLT/SLTU produce 32'h0 or 32'h1.
- Any other opcode, or an undefined func3/func7 combination, produces result 0. It is still broadcast so the tag retires.
- o_operand_err pulses on a pop of a non-bubble entry with rs1_valid=0 or rs2_valid=0. The operation executes anyway with the supplied data.
- REQ -> IDLE: on grant with no simultaneous pop, or on i_flush.
- IDLE -> REQ: on a pop of a non-bubble entry.
- REQ -> REQ: grant plus a non-bubble pop replaces the result in the same edge.
- o_cdb_tag and o_cdb_data stay stable while o_cdb_req=1 and no grant is given.

## Timing
- Reset values: o_cdb_req=0, o_cdb_tag=0, o_cdb_data=0, o_operand_err=0. o_fifo_rd=0 while rst=1.
- Latency: pop at edge N, o_cdb_req=1 during cycle N+1 with the result. Pop-to-broadcast is one cycle.
- Throughput: one result per cycle while i_cdb_grant is held at 1 and the FIFO is non-empty.
- Backpressure: with req=1 and grant=0, o_fifo_rd=0. The FIFO head is held indefinitely.
- Empty FIFO: no pop. A granted result still clears to IDLE.
- i_flush has priority over grant and pop: the result register clears to IDLE at the next edge and no pop occurs that cycle.
- i_flush has no effect when already IDLE.
- rst asserted mid-request clears the result at that edge without a handshake. The entry is lost; this is acceptable because reset flushes the dispatcher too.
- Grant while req=0 is ignored.

## Test plan
- Reset: rst=1 for 2 cycles with the FIFO non-empty -> o_fifo_rd=0, o_cdb_req=0, tag/data=0.
- ADD then SUB, grant tied 1:
  - ADD with rs1=5, rs2=7, rd_tag=0x0A -> cycle after pop: req=1, tag=0x0A, data=0x0000000C.
  - Next cycle SUB 5-7 -> data=0xFFFFFFFE, back-to-back pops.
- Backpressure: XORI rs1=0xF0F0F0F0, imm=0xFFFFFFFF, grant=0 for 3 cycles -> data=0x0F0F0F0F held stable, o_fifo_rd=0, single pop after grant.
- Shifts/compares:
  - SRA 0x80000000 by 31 -> 0xFFFFFFFF; SRL gives 0x00000001.
  - SLT -1<1 -> 1; SLTU -1<1 -> 0.
- Bubble/unsupported: opcode 0 -> popped, no req. Opcode 7'h03 with rd_tag=0x11 -> req with tag=0x11, data=0.
- Flush and operand error:
  - i_flush during REQ with grant=0 -> req=0 next cycle, no pop that cycle.
  - Entry with rs2_valid=0 -> o_operand_err=1 for exactly one cycle.

Source files
------------

// File: rtl/int_exec_unit.sv
// Integer execution unit: pops ready integer ops from the dispatch FIFO, evaluates
// them in one cycle and holds the result on the CDB until the arbiter grants it.
module int_exec_unit #(
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32,
    parameter int ENTRY_W = 101
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_fifo_empty,
    input  logic [ENTRY_W-1:0] i_fifo_data,
    output logic               o_fifo_rd,
    output logic               o_cdb_req,
    output logic [TAG_W-1:0]   o_cdb_tag,
    output logic [DATA_W-1:0]  o_cdb_data,
    input  logic               i_cdb_grant,
    input  logic               i_flush,
    output logic               o_operand_err
);

    // Field positions, packed from the LSB upward: rd, rs2 tag/valid/data, rs1 tag/valid/data, func7, func3, opcode
    localparam int RD_LSB   = 0;
    localparam int RS2T_LSB = RD_LSB + TAG_W;
    localparam int RS2V_BIT = RS2T_LSB + TAG_W;
    localparam int RS2D_LSB = RS2V_BIT + 1;
    localparam int RS1T_LSB = RS2D_LSB + DATA_W;
    localparam int RS1V_BIT = RS1T_LSB + TAG_W;
    localparam int RS1D_LSB = RS1V_BIT + 1;
    localparam int F7_LSB   = RS1D_LSB + DATA_W;
    localparam int F3_LSB   = F7_LSB + 7;
    localparam int OP_LSB   = F3_LSB + 3;

    localparam logic [6:0] OP_BUBBLE = 7'h00;
    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;

    typedef enum logic {IDLE, REQ} state_t;

    state_t             state_reg, state_next;
    logic [TAG_W-1:0]   tag_reg;
    logic [DATA_W-1:0]  data_reg;
    logic               err_reg, err_next;

    logic [6:0]         opcode;
    logic [2:0]         func3;
    logic [6:0]         func7;
    logic [DATA_W-1:0]  op_a, op_b;
    logic               a_valid, b_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [4:0]         shamt;
    logic [DATA_W-1:0]  alu_result;
    logic               pop, load;
    logic               tags_unused;

    assign opcode  = i_fifo_data[OP_LSB +: 7];
    assign func3   = i_fifo_data[F3_LSB +: 3];
    assign func7   = i_fifo_data[F7_LSB +: 7];
    assign op_a    = i_fifo_data[RS1D_LSB +: DATA_W];
    assign a_valid = i_fifo_data[RS1V_BIT];
    assign op_b    = i_fifo_data[RS2D_LSB +: DATA_W];
    assign b_valid = i_fifo_data[RS2V_BIT];
    assign rd_tag  = i_fifo_data[RD_LSB +: TAG_W];
    assign shamt   = op_b[4:0];

    // Source tags are only meaningful to the dispatcher's wakeup logic.
    assign tags_unused = ^{i_fifo_data[RS1T_LSB +: TAG_W], i_fifo_data[RS2T_LSB +: TAG_W]};

    // ALU; undefined encodings and unknown opcodes fall through to zero so the tag still retires.
    always_comb begin
        alu_result = '0;
        if (opcode == OP_R || opcode == OP_I) begin
            unique case (func3)
                3'd0: begin
                    if (opcode == OP_I || func7 == F7_BASE)
                        alu_result = op_a + op_b;
                    else if (func7 == F7_ALT)
                        alu_result = op_a - op_b;
                end
                3'd1: alu_result = op_a << shamt;
                3'd2: alu_result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                3'd3: alu_result = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
                3'd4: alu_result = op_a ^ op_b;
                3'd5: begin
                    if (func7 == F7_BASE)
                        alu_result = op_a >> shamt;
                    else if (func7 == F7_ALT)
                        alu_result = DATA_W'($signed(op_a) >>> shamt);
                end
                3'd6: alu_result = op_a | op_b;
                3'd7: alu_result = op_a & op_b;
                default: alu_result = '0;
            endcase
        end
    end

    // A new entry may be taken when the result slot is empty or is being handed off this edge.
    assign pop  = !i_fifo_empty && !i_flush && !rst && (state_reg == IDLE || i_cdb_grant);
    assign load = pop && (opcode != OP_BUBBLE);

    always_comb begin
        state_next = state_reg;
        err_next   = 1'b0;
        if (i_flush) begin
            state_next = IDLE;
        end else if (load) begin
            state_next = REQ;
            err_next   = !a_valid || !b_valid;
        end else if (state_reg == REQ && i_cdb_grant) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            tag_reg   <= '0;
            data_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
            if (load) begin
                tag_reg  <= rd_tag;
                data_reg <= alu_result;
            end
        end
    end

    assign o_fifo_rd     = pop;
    assign o_cdb_req     = (state_reg == REQ);
    assign o_cdb_tag     = tag_reg;
    assign o_cdb_data    = data_reg;
    assign o_operand_err = err_reg;

endmodule

// File: tb/tb_int_exec_unit.sv
// Self-checking bench for int_exec_unit: FIFO model, vector table and result scoreboard.
module tb_int_exec_unit;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  tag;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] data;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         fifo_empty;
    logic [100:0] fifo_head;
    logic         fifo_rd;
    logic         cdb_req;
    logic [5:0]   cdb_tag;
    logic [31:0]  cdb_data;
    logic         cdb_grant;
    logic         flush;
    logic         operand_err;

    logic [100:0] fifo_q[$];
    res_t         sb[$];
    vec_t         tbl[20];

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    int req_cnt = 0;
    int pop_cnt = 0;
    int stall_cnt = 0;
    logic exp_req_now = 1'b0;

    always #5 clk = ~clk;

    int_exec_unit dut (
        .clk          (clk),
        .rst          (rst),
        .i_fifo_empty (fifo_empty),
        .i_fifo_data  (fifo_head),
        .o_fifo_rd    (fifo_rd),
        .o_cdb_req    (cdb_req),
        .o_cdb_tag    (cdb_tag),
        .o_cdb_data   (cdb_data),
        .i_cdb_grant  (cdb_grant),
        .i_flush      (flush),
        .o_operand_err(operand_err)
    );

    function automatic logic [100:0] mk(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                        logic [31:0] a, logic av, logic [31:0] b, logic bv,
                                        logic [5:0] rd);
        return {op, f3, f7, a, av, 6'h3F, b, bv, 6'h2A, rd};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    task automatic fifo_sync();
        fifo_empty = (fifo_q.size() == 0);
        fifo_head  = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic push(logic [100:0] e);
        fifo_q.push_back(e);
        fifo_sync();
    endtask

    task automatic push_exp(logic [100:0] e, logic [5:0] tag, logic [31:0] data);
        res_t r;
        r.tag  = tag;
        r.data = data;
        sb.push_back(r);
        push(e);
    endtask

    // One clock: observe at the falling edge, then step past the rising edge and retire any pop.
    task automatic clk_cycle();
        logic popped;
        res_t r;
        @(negedge clk);
        popped = fifo_rd;
        if (!rst) begin
            if (exp_req_now)
                chk("latency_req", {31'd0, cdb_req}, 32'd1);
            if (cdb_req && cdb_grant) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", {26'd0, cdb_tag}, 32'hFFFF_FFFF);
                end else begin
                    r = sb.pop_front();
                    chk("sb_tag", {26'd0, cdb_tag}, {26'd0, r.tag});
                    chk("sb_data", cdb_data, r.data);
                end
            end
            err_cnt += int'(operand_err);
            req_cnt += int'(cdb_req);
            pop_cnt += int'(fifo_rd);
            if (cdb_grant && !flush && !fifo_empty && !fifo_rd)
                stall_cnt++;
        end
        exp_req_now = fifo_rd && (fifo_head[100:94] != 7'h00);
        @(posedge clk);
        #1;
        if (popped)
            void'(fifo_q.pop_front());
        fifo_sync();
    endtask

    task automatic drain();
        cdb_grant = 1'b1;
        for (int k = 0; k < 200 && (sb.size() != 0 || fifo_q.size() != 0 || cdb_req); k++)
            clk_cycle();
        chk("drain_complete", sb.size(), 32'd0);
    endtask

    task automatic wait_req();
        for (int k = 0; k < 10 && !cdb_req; k++)
            clk_cycle();
        chk("req_seen", {31'd0, cdb_req}, 32'd1);
    endtask

    initial begin
        int p0;
        tbl[0]  = '{7'h33, 3'd0, 7'h20, 32'd5,          32'd7,          6'h0B, 32'hFFFF_FFFE};
        tbl[1]  = '{7'h33, 3'd5, 7'h20, 32'h8000_0000,  32'd31,         6'h0C, 32'hFFFF_FFFF};
        tbl[2]  = '{7'h33, 3'd5, 7'h00, 32'h8000_0000,  32'd31,         6'h0D, 32'h0000_0001};
        tbl[3]  = '{7'h33, 3'd2, 7'h00, 32'hFFFF_FFFF,  32'd1,          6'h0E, 32'h0000_0001};
        tbl[4]  = '{7'h33, 3'd3, 7'h00, 32'hFFFF_FFFF,  32'd1,          6'h0F, 32'h0000_0000};
        tbl[5]  = '{7'h33, 3'd1, 7'h00, 32'd1,          32'd35,         6'h10, 32'h0000_0008};
        tbl[6]  = '{7'h33, 3'd4, 7'h00, 32'hFF00_FF00,  32'h0F0F_0F0F,  6'h12, 32'hF00F_F00F};
        tbl[7]  = '{7'h33, 3'd6, 7'h00, 32'h0000_00F0,  32'h0000_000F,  6'h13, 32'h0000_00FF};
        tbl[8]  = '{7'h33, 3'd7, 7'h00, 32'h0000_F0F0,  32'h0000_FF00,  6'h14, 32'h0000_F000};
        tbl[9]  = '{7'h13, 3'd0, 7'h00, 32'hFFFF_FFFF,  32'd1,          6'h15, 32'h0000_0000};
        tbl[10] = '{7'h13, 3'd2, 7'h00, 32'd5,          32'hFFFF_FFFD,  6'h16, 32'h0000_0000};
        tbl[11] = '{7'h13, 3'd3, 7'h00, 32'd5,          32'hFFFF_FFFD,  6'h17, 32'h0000_0001};
        tbl[12] = '{7'h13, 3'd5, 7'h20, 32'hF000_0000,  32'd4,          6'h18, 32'hFF00_0000};
        tbl[13] = '{7'h03, 3'd0, 7'h00, 32'd9,          32'd9,          6'h11, 32'h0000_0000};
        tbl[14] = '{7'h33, 3'd0, 7'h01, 32'd9,          32'd9,          6'h19, 32'h0000_0000};
        tbl[15] = '{7'h13, 3'd6, 7'h00, 32'h0000_1200,  32'h0000_0034,  6'h1A, 32'h0000_1234};
        tbl[16] = '{7'h13, 3'd1, 7'h00, 32'd3,          32'd2,          6'h1B, 32'h0000_000C};
        tbl[17] = '{7'h13, 3'd7, 7'h00, 32'h0000_ABCD,  32'h0000_00FF,  6'h1C, 32'h0000_00CD};
        tbl[18] = '{7'h13, 3'd5, 7'h00, 32'hF000_0000,  32'd4,          6'h1D, 32'h0F00_0000};
        tbl[19] = '{7'h13, 3'd4, 7'h00, 32'h1234_5678,  32'hFFFF_FFFF,  6'h1E, 32'hEDCB_A987};

        // Reset with a pending FIFO entry (ADD 5+7 -> tag 0x0A)
        rst = 1'b1;
        flush = 1'b0;
        cdb_grant = 1'b0;
        push_exp(mk(7'h33, 3'd0, 7'h00, 32'd5, 1'b1, 32'd7, 1'b1, 6'h0A), 6'h0A, 32'h0000_000C);
        for (int c = 0; c < 2; c++) begin
            clk_cycle();
            chk("reset_rd", {31'd0, fifo_rd}, 32'd0);
            chk("reset_req", {31'd0, cdb_req}, 32'd0);
            chk("reset_tag", {26'd0, cdb_tag}, 32'd0);
            chk("reset_data", cdb_data, 32'd0);
        end
        chk("reset_err", {31'd0, operand_err}, 32'd0);
        rst = 1'b0;

        // Vector table with grant held high: one pop per cycle, no stalls
        cdb_grant = 1'b1;
        stall_cnt = 0;
        err_cnt = 0;
        foreach (tbl[i])
            push_exp(mk(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].a, 1'b1, tbl[i].b, 1'b1, tbl[i].tag),
                     tbl[i].tag, tbl[i].exp);
        drain();
        chk("throughput_stalls", stall_cnt, 32'd0);
        chk("table_no_err", err_cnt, 32'd0);

        // Backpressure: result held, head not consumed until grant
        cdb_grant = 1'b0;
        push_exp(mk(7'h13, 3'd4, 7'h00, 32'hF0F0_F0F0, 1'b1, 32'hFFFF_FFFF, 1'b1, 6'h30), 6'h30, 32'h0F0F_0F0F);
        push_exp(mk(7'h33, 3'd0, 7'h00, 32'd1, 1'b1, 32'd1, 1'b1, 6'h31), 6'h31, 32'd2);
        wait_req();
        p0 = pop_cnt;
        for (int c = 0; c < 3; c++) begin
            clk_cycle();
            chk("bp_req", {31'd0, cdb_req}, 32'd1);
            chk("bp_data", cdb_data, 32'h0F0F_0F0F);
            chk("bp_rd", {31'd0, fifo_rd}, 32'd0);
        end
        chk("bp_no_pop", pop_cnt - p0, 32'd0);
        cdb_grant = 1'b1;
        clk_cycle();
        chk("bp_single_pop", pop_cnt - p0, 32'd1);
        chk("bp_next_tag", {26'd0, cdb_tag}, 32'h31);
        drain();

        // Bubble: consumed, never requests
        req_cnt = 0;
        push(mk(7'h00, 3'd0, 7'h00, 32'd1, 1'b1, 32'd2, 1'b1, 6'h3A));
        for (int c = 0; c < 4; c++)
            clk_cycle();
        chk("bubble_popped", fifo_q.size(), 32'd0);
        chk("bubble_no_req", req_cnt, 32'd0);

        // Flush during REQ with grant low
        cdb_grant = 1'b0;
        push(mk(7'h33, 3'd0, 7'h00, 32'd3, 1'b1, 32'd4, 1'b1, 6'h21));
        push_exp(mk(7'h33, 3'd0, 7'h00, 32'd10, 1'b1, 32'd20, 1'b1, 6'h22), 6'h22, 32'd30);
        wait_req();
        chk("flush_pre_tag", {26'd0, cdb_tag}, 32'h21);
        flush = 1'b1;
        #1;
        chk("flush_no_pop", {31'd0, fifo_rd}, 32'd0);
        clk_cycle();
        flush = 1'b0;
        chk("flush_req_clear", {31'd0, cdb_req}, 32'd0);
        chk("flush_head_kept", fifo_q.size(), 32'd1);
        clk_cycle();
        chk("flush_next_tag", {26'd0, cdb_tag}, 32'h22);
        drain();

        // Operand error: rs2_valid=0 still executes, pulse lasts one cycle
        err_cnt = 0;
        push_exp(mk(7'h33, 3'd0, 7'h00, 32'd1, 1'b1, 32'd2, 1'b0, 6'h05), 6'h05, 32'd3);
        for (int c = 0; c < 5; c++)
            clk_cycle();
        chk("err_pulse_count", err_cnt, 32'd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
